// File: rtl/iterative_mult_pkg.sv
// Shared types and helpers for the iterative arithmetic blocks.
// Latency: n/a; backpressure: n/a.
package iterative_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Conditional two's-complement magnitude. Callers pass a zero-extended
    // W-bit operand and keep only the low W bits of the result.
    // That also makes the most-negative input map to 2^(W-1).
    function automatic logic [31:0] abs_w(input logic [31:0] val, input logic negate);
        return negate ? (~val + 32'd1) : val;
    endfunction

endpackage

// File: rtl/iterative_mult_hs.sv
// Shift-and-add multiplier, signed or unsigned per transaction, valid/ready on both sides.
// Latency: WIDTH cycles from accept to out_valid. Backpressure: DONE holds while out_ready is low.
// in_ready is high only in IDLE.
module iterative_mult_hs
    import iterative_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               busy
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             neg_q, neg_d;

    logic [WIDTH-1:0] mag1, mag2;
    logic [PW-1:0]    acc_sum;

    always_comb begin
        mag1 = WIDTH'(abs_w(32'(in1), in_signed & in1[WIDTH-1]));
        mag2 = WIDTH'(abs_w(32'(in2), in_signed & in2[WIDTH-1]));
        acc_sum = acc_q + (mplier_q[cnt_q] ? (mcand_q << cnt_q) : {PW{1'b0}});

        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = PW'(mag1);
                    mplier_d = mag2;
                    neg_d    = in_signed & (in1[WIDTH-1] ^ in2[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CNT_W'(1);
                // Explicit terminal count; the counter is parked at 0 instead of wrapping.
                if (cnt_q == CNT_LAST) begin
                    acc_d   = neg_q ? (~acc_sum + PW'(1)) : acc_sum;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
        end
    end

    // acc_q doubles as the result register once in DONE.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out       = out_valid ? acc_q : {PW{1'b0}};

endmodule
